event_unit_sleep_ctrl: RTL

Per-core sleep/wake controller that sits directly downstream of the event unit's per-core event buffer/mask stage. It consumes the masked event-detect flag and the masked buffer status, puts the core to sleep on request by dropping its clock enable, and wakes the core when a masked event is pending. On wake it reports the wake cause and can optionally clear the consumed events in the upstream buffer. One instance per core.

---
 rtl/event_unit_sleep_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/event_unit_sleep_ctrl.sv
// Per-core sleep/wake controller downstream of the event unit buffer/mask stage.
// Optional sleep timeout is built only when EU_SLEEP_TIMEOUT_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | core running, waiting for a sleep request
// DRAIN | sleep requested, core still busy; clock kept on
// SLEEP | core clock gated, waiting for an event (or timeout)
// WAKE  | one-cycle wake: ack, latch cause, optional buffer clear
module event_unit_sleep_ctrl #(
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 test_mode_i,
   input  logic                 sleep_req_i,
   input  logic                 sleep_clear_i,
   input  logic                 core_busy_i,
   input  logic                 event_detect_i,
   input  logic [31:0]          event_status_i,
   input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
   output logic                 core_clock_en_o,
   output logic                 sleep_ack_o,
   output logic                 sleep_status_o,
   output logic [31:0]          wake_cause_o,
   output logic [63:0]          evnt_buffer_clear_o,
   output logic                 timeout_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_clear_mode;
   logic        w_clear_mode_nxt;
   logic        w_clear_eff;
   logic        w_timeout_hit;
   logic        w_timeout_wake;
   logic        w_waiting;
   logic        r_clk_en;
   logic        r_ack;
   logic        r_status;
   logic        r_timeout;
   logic [31:0] r_wake_cause;
   logic [31:0] r_clear;

   assign w_waiting = (r_state == ST_DRAIN) || (r_state == ST_SLEEP);

`ifdef EU_SLEEP_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_cnt;

   // Loaded only on leaving RUN, so DRAIN -> SLEEP keeps the running count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if ((w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SLEEP)) begin
            r_cnt <= timeout_cycles_i;
         end
      end else if (w_waiting) begin
         if (w_state_nxt == ST_WAKE) begin
            r_cnt <= '0;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TIMEOUT_W'(1);
         end
      end
   end

   assign w_timeout_hit = w_waiting && (r_cnt == TIMEOUT_W'(1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^timeout_cycles_i;
   assign w_timeout_hit    = 1'b0;
`endif

   assign w_timeout_wake = w_timeout_hit && !event_detect_i;
   // A wake straight from RUN uses the qualifier sampled with the request.
   assign w_clear_eff    = (r_state == ST_RUN) ? sleep_clear_i : r_clear_mode;

   always_comb begin
      w_state_nxt      = r_state;
      w_clear_mode_nxt = r_clear_mode;
      case (r_state)
         ST_RUN: begin
            if (sleep_req_i) begin
               w_clear_mode_nxt = sleep_clear_i;
               if (event_detect_i) begin
                  w_state_nxt = ST_WAKE;
               end else if (core_busy_i) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_state_nxt = ST_SLEEP;
               end
            end
         end
         ST_DRAIN: begin
            if (event_detect_i || w_timeout_hit) begin
               w_state_nxt = ST_WAKE;
            end else if (!core_busy_i) begin
               w_state_nxt = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            if (event_detect_i || w_timeout_hit) begin
               w_state_nxt = ST_WAKE;
            end
         end
         ST_WAKE: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_RUN;
         r_clear_mode <= 1'b0;
         r_clk_en     <= 1'b1;
         r_ack        <= 1'b0;
         r_status     <= 1'b0;
         r_timeout    <= 1'b0;
         r_wake_cause <= '0;
         r_clear      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_clear_mode <= w_clear_mode_nxt;
         r_clk_en     <= (w_state_nxt != ST_SLEEP);
         r_ack        <= (w_state_nxt == ST_WAKE);
         r_status     <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SLEEP);
         r_timeout    <= (w_state_nxt == ST_WAKE) && w_timeout_wake;
         r_clear      <= '0;
         if (w_state_nxt == ST_WAKE) begin
            r_wake_cause <= w_timeout_wake ? 32'h0 : event_status_i;
            if (w_clear_eff && !w_timeout_wake) begin
               r_clear <= event_status_i;
            end
         end
      end
   end

   assign core_clock_en_o     = r_clk_en | test_mode_i;
   assign sleep_ack_o         = r_ack;
   assign sleep_status_o      = r_status;
   assign timeout_o           = r_timeout;
   assign wake_cause_o        = r_wake_cause;
   assign evnt_buffer_clear_o = {32'h0, r_clear};

endmodule
